fb_plotter: RTL and testbench

- Write-side engine for the 1-bit display framebuffer (sdp BRAM write port).
- Accepts particle coordinates from the fluid simulation over a valid/ready handshake and rasterises each one as a DOT_SIZE x DOT_SIZE square, clipping it to the screen.
- Also performs a full-frame clear sweep on request.
- Drives draw_addr_write / draw_data_in / draw_we directly; the VGA read side runs independently on vga_clk.

---
 rtl/fb_plotter.sv | 196 +++++++++++++++++++
 tb/tb_fb_plotter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_plotter.sv
// fb_plotter: write-side engine for the 1-bit display framebuffer.
// It rasterises each accepted particle as a DOT_SIZE x DOT_SIZE square and
// clips that square to the screen. It also sweeps the whole frame on a
// clear request.
// Optional feature: define FB_PLOTTER_CLIP_COUNT_EN to add the clip_count
// output, a saturating count of off-screen plot beats.
`timescale 1ns/1ps

module fb_plotter #(
    parameter int unsigned DRAW_WIDTH  = 640,
    parameter int unsigned DRAW_HEIGHT = 480,
    parameter int unsigned DRAW_SIZE   = DRAW_WIDTH * DRAW_HEIGHT,
    parameter int unsigned DRAW_ADDRW  = $clog2(DRAW_SIZE),
    parameter int unsigned DRAW_DATAW  = 1,
    parameter int unsigned COORDW      = 10,
    parameter int unsigned DOT_SIZE    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_start,
    input  logic [DRAW_DATAW-1:0] clear_color,
    input  logic                  pt_valid,
    output logic                  pt_ready,
    input  logic [COORDW-1:0]     pt_x,
    input  logic [COORDW-1:0]     pt_y,
    input  logic [DRAW_DATAW-1:0] pt_color,
    output logic                  busy,
    output logic                  done,
`ifdef FB_PLOTTER_CLIP_COUNT_EN
    output logic [15:0]           clip_count,
`endif
    output logic [DRAW_ADDRW-1:0] draw_addr_write,
    output logic [DRAW_DATAW-1:0] draw_data_in,
    output logic                  draw_we
);

    localparam int unsigned SUMW = COORDW + 1;
    localparam int unsigned DOTW = (DOT_SIZE > 1) ? $clog2(DOT_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PLOT  = 2'd2
    } state_t;

    state_t                  state;
    logic [DRAW_ADDRW-1:0]   clr_addr;
    logic [DRAW_DATAW-1:0]   lat_color;
    logic [COORDW-1:0]       lat_x;
    logic [COORDW-1:0]       lat_y;
    logic [DOTW-1:0]         dx;
    logic [DOTW-1:0]         dy;

    logic [COORDW-1:0]       src_x;
    logic [COORDW-1:0]       src_y;
    logic [DRAW_DATAW-1:0]   src_color;
    logic [DOTW-1:0]         src_dx;
    logic [DOTW-1:0]         src_dy;
    logic [DOTW-1:0]         next_dx;
    logic [DOTW-1:0]         next_dy;
    logic [SUMW-1:0]         beat_px;
    logic [SUMW-1:0]         beat_py;
    logic                    beat_in;
    logic                    dot_last;
    logic [DRAW_ADDRW-1:0]   beat_addr;

    // Clear has priority over a pending point, so readiness drops with clear_start.
    assign pt_ready = (state == IDLE) && !clear_start;

    // Current plot beat. In IDLE this is the first beat of the point on the
    // input bus, so the beat can issue on the accepting edge.
    always_comb begin
        src_x     = pt_x;
        src_y     = pt_y;
        src_color = pt_color;
        src_dx    = '0;
        src_dy    = '0;
        if (state == PLOT) begin
            src_x     = lat_x;
            src_y     = lat_y;
            src_color = lat_color;
            src_dx    = dx;
            src_dy    = dy;
        end
        beat_px   = SUMW'(src_x) + SUMW'(src_dx);
        beat_py   = SUMW'(src_y) + SUMW'(src_dy);
        beat_in   = (32'(beat_px) < DRAW_WIDTH) && (32'(beat_py) < DRAW_HEIGHT);
        beat_addr = DRAW_ADDRW'(beat_py) * DRAW_ADDRW'(DRAW_WIDTH)
                  + DRAW_ADDRW'(beat_px);
        dot_last  = (src_dx == DOTW'(DOT_SIZE - 1)) && (src_dy == DOTW'(DOT_SIZE - 1));
        next_dx   = src_dx;
        next_dy   = src_dy;
        if (src_dx == DOTW'(DOT_SIZE - 1)) begin
            next_dx = '0;
            next_dy = src_dy + DOTW'(1);
        end else begin
            next_dx = src_dx + DOTW'(1);
        end
    end

    // Control FSM with registered framebuffer write port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            clr_addr        <= '0;
            lat_color       <= '0;
            lat_x           <= '0;
            lat_y           <= '0;
            dx              <= '0;
            dy              <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            draw_we         <= 1'b0;
            draw_addr_write <= '0;
            draw_data_in    <= '0;
`ifdef FB_PLOTTER_CLIP_COUNT_EN
            clip_count      <= '0;
`endif
        end else begin
            draw_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (clear_start) begin
                        lat_color       <= clear_color;
                        busy            <= 1'b1;
                        draw_we         <= 1'b1;
                        draw_addr_write <= '0;
                        draw_data_in    <= clear_color;
                        clr_addr        <= DRAW_ADDRW'(1);
`ifdef FB_PLOTTER_CLIP_COUNT_EN
                        clip_count      <= '0;
`endif
                        if (DRAW_SIZE == 1) begin
                            done <= 1'b1;
                        end else begin
                            state <= CLEAR;
                        end
                    end else if (pt_valid) begin
                        lat_x           <= pt_x;
                        lat_y           <= pt_y;
                        lat_color       <= pt_color;
                        busy            <= 1'b1;
                        draw_we         <= beat_in;
                        draw_addr_write <= beat_addr;
                        draw_data_in    <= src_color;
`ifdef FB_PLOTTER_CLIP_COUNT_EN
                        if (!beat_in && clip_count != 16'hFFFF)
                            clip_count <= clip_count + 16'd1;
`endif
                        if (dot_last) begin
                            done <= 1'b1;
                        end else begin
                            dx    <= next_dx;
                            dy    <= next_dy;
                            state <= PLOT;
                        end
                    end
                end
                CLEAR: begin
                    draw_we         <= 1'b1;
                    draw_addr_write <= clr_addr;
                    draw_data_in    <= lat_color;
                    if (clr_addr == DRAW_ADDRW'(DRAW_SIZE - 1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        clr_addr <= clr_addr + DRAW_ADDRW'(1);
                    end
                end
                PLOT: begin
                    draw_we         <= beat_in;
                    draw_addr_write <= beat_addr;
                    draw_data_in    <= src_color;
`ifdef FB_PLOTTER_CLIP_COUNT_EN
                    if (!beat_in && clip_count != 16'hFFFF)
                        clip_count <= clip_count + 16'd1;
`endif
                    if (dot_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        dx <= next_dx;
                        dy <= next_dy;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_plotter.sv
// tb_fb_plotter: scoreboard bench for fb_plotter.
// The frame is 640 x 32 so that a full clear stays short. Columns keep the
// real 640-pixel stride. Define FB_PLOTTER_CLIP_COUNT_EN to also check
// clip_count.
`timescale 1ns/1ps

module tb_fb_plotter;

    localparam int unsigned W    = 640;
    localparam int unsigned H    = 32;
    localparam int unsigned SIZE = W * H;
    localparam int unsigned AW   = $clog2(SIZE);

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic          data;
        logic          dn;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          clear_start;
    logic [0:0]    clear_color;
    logic          pt_valid;
    logic          pt_ready;
    logic [9:0]    pt_x;
    logic [9:0]    pt_y;
    logic [0:0]    pt_color;
    logic          busy;
    logic          done;
    logic [AW-1:0] draw_addr_write;
    logic [0:0]    draw_data_in;
    logic          draw_we;
`ifdef FB_PLOTTER_CLIP_COUNT_EN
    logic [15:0]   clip_count;
`endif

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n;

    fb_plotter #(.DRAW_WIDTH(W), .DRAW_HEIGHT(H)) dut (
        .clk             (clk),
        .rst             (rst),
        .clear_start     (clear_start),
        .clear_color     (clear_color),
        .pt_valid        (pt_valid),
        .pt_ready        (pt_ready),
        .pt_x            (pt_x),
        .pt_y            (pt_y),
        .pt_color        (pt_color),
        .busy            (busy),
        .done            (done),
`ifdef FB_PLOTTER_CLIP_COUNT_EN
        .clip_count      (clip_count),
`endif
        .draw_addr_write (draw_addr_write),
        .draw_data_in    (draw_data_in),
        .draw_we         (draw_we)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d beats still queued", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: every busy cycle is one write beat, checked against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat_unexpected: got we=%0d addr=%0d data=%0d done=%0d, required no beat",
                             draw_we, draw_addr_write, draw_data_in, done);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (draw_we !== e.we || done !== e.dn ||
                        (e.we && (draw_addr_write !== e.addr || draw_data_in !== e.data))) begin
                        n_bad++;
                        $display("FAIL beat: got we=%0d addr=%0d data=%0d done=%0d, required we=%0d addr=%0d data=%0d done=%0d",
                                 draw_we, draw_addr_write, draw_data_in, done,
                                 e.we, e.addr, e.data, e.dn);
                    end
                end
            end else if (draw_we !== 1'b0 || done !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL idle_quiet: got we=%0d done=%0d while not busy, required 0/0", draw_we, done);
            end
        end
    end

    task automatic push(input logic we, input int addr, input logic data, input logic dn);
        beat_t b;
        b.we   = we;
        b.addr = AW'(addr);
        b.data = data;
        b.dn   = dn;
        exp_q.push_back(b);
    endtask

    task automatic push_clear(input logic color);
        for (int a = 0; a < int'(SIZE); a++)
            push(1'b1, a, color, a == int'(SIZE) - 1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Counts busy cycles from the next negedge until busy falls.
    task automatic wait_idle(output int cnt);
        int k;
        cnt = 0;
        k   = 0;
        @(negedge clk);
        while (busy && k < 25000) begin
            cnt++;
            k++;
            @(negedge clk);
        end
    endtask

    // Waits for pt_ready at a negedge. Returns just before the accepting edge.
    task automatic wait_ready(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!pt_ready && k < 25000) begin
            k++;
            @(negedge clk);
        end
        check(name, 32'(pt_ready), 1);
    endtask

    task automatic send_point(input int x, input int y, input logic c);
        @(posedge clk); #1;
        pt_valid = 1'b1;
        pt_x     = 10'(x);
        pt_y     = 10'(y);
        pt_color = c;
        wait_ready("point_ready");
        @(posedge clk); #1;
        pt_valid = 1'b0;
    endtask

    task automatic start_clear(input logic c);
        @(posedge clk); #1;
        clear_start = 1'b1;
        clear_color = c;
        @(posedge clk); #1;
        clear_start = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        clear_start = 1'b0;
        clear_color = 1'b0;
        pt_valid    = 1'b0;
        pt_x        = '0;
        pt_y        = '0;
        pt_color    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_we",    32'(draw_we), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_addr",  32'(draw_addr_write), 0);
        check("rst_data",  32'(draw_data_in), 0);
        check("rst_ready", 32'(pt_ready), 1);
`ifdef FB_PLOTTER_CLIP_COUNT_EN
        check("rst_clip", 32'(clip_count), 0);
`endif

        // Full clear to 0
        push_clear(1'b0);
        start_clear(1'b0);
        wait_idle(n);
        check("clear_len", 32'(n), SIZE);

        // Point (10,20): a fully visible dot
        push(1, 12810, 1, 0);
        push(1, 12811, 1, 0);
        push(1, 13450, 1, 0);
        push(1, 13451, 1, 1);
        send_point(10, 20, 1'b1);
        wait_idle(n);
        check("pt_10_20_len", 32'(n), 4);

        // Bottom-right corner: only the first beat lands on screen
        push(1, 20479, 1, 0);
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        push(0, 0, 0, 1);
        send_point(639, 31, 1'b1);
        wait_idle(n);
        check("pt_corner_len", 32'(n), 4);
`ifdef FB_PLOTTER_CLIP_COUNT_EN
        check("clip_corner", 32'(clip_count), 3);
`endif

        // Fully off-screen at the coordinate maximum; x+dx needs the extra bit
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        push(0, 0, 0, 1);
        send_point(1023, 1023, 1'b1);
        wait_idle(n);
        check("pt_offscreen_len", 32'(n), 4);
`ifdef FB_PLOTTER_CLIP_COUNT_EN
        check("clip_offscreen", 32'(clip_count), 7);
`endif

        // Back-to-back points with pt_valid held high
        push(1, 0,   1, 0);
        push(1, 1,   1, 0);
        push(1, 640, 1, 0);
        push(1, 641, 1, 1);
        push(1, 2,   0, 0);
        push(1, 3,   0, 0);
        push(1, 642, 0, 0);
        push(1, 643, 0, 1);
        @(posedge clk); #1;
        pt_valid = 1'b1;
        pt_x     = 10'd0;
        pt_y     = 10'd0;
        pt_color = 1'b1;
        wait_ready("b2b_first_ready");
        @(posedge clk); #1;
        pt_x     = 10'd2;
        pt_color = 1'b0;
        wait_ready("b2b_second_ready");
        check("b2b_ready_in_done", 32'(done), 1);
        @(posedge clk); #1;
        pt_valid = 1'b0;
        wait_idle(n);
        check("b2b_no_bubble", 32'(n), 4);

        // Clear wins over a simultaneous point, which waits for the clear's done
        push_clear(1'b1);
        push(1, 3845, 1, 0);
        push(1, 3846, 1, 0);
        push(1, 4485, 1, 0);
        push(1, 4486, 1, 1);
        @(posedge clk); #1;
        clear_start = 1'b1;
        clear_color = 1'b1;
        pt_valid    = 1'b1;
        pt_x        = 10'd5;
        pt_y        = 10'd6;
        pt_color    = 1'b1;
        @(negedge clk);
        check("prio_ready_low", 32'(pt_ready), 0);
        @(posedge clk); #1;
        clear_start = 1'b0;
        wait_ready("prio_point_ready");
        check("prio_done_with_ready", 32'(done), 1);
        check("prio_last_addr", 32'(draw_addr_write), SIZE - 1);
        @(posedge clk); #1;
        pt_valid = 1'b0;
        wait_idle(n);
        check("prio_point_follows", 32'(n), 4);
`ifdef FB_PLOTTER_CLIP_COUNT_EN
        check("clip_cleared", 32'(clip_count), 0);
`endif

        // Reset in the middle of a clear
        for (int a = 0; a <= 1000; a++)
            push(1'b1, a, 1'b0, 1'b0);
        start_clear(1'b0);
        n = 0;
        @(negedge clk);
        while (draw_addr_write != AW'(1000) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("abort_reached_1000", 32'(draw_addr_write), 1000);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        check("abort_we",   32'(draw_we), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(pt_ready), 1);
        check("abort_idle",  32'(busy), 0);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
